// File: rtl/mul_addshift_radix_if.sv
// Operand/result handshake bundle for the radix add-shift multiplier.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on operands, out_valid/out_ready on the product.
interface mul_addshift_radix_if #(
    parameter int DATA_W = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  sign_a;
    logic                  sign_b;
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   product;

    // Requester side: issues operands, consumes the product.
    modport master (
        output in_valid, sign_a, sign_b, op_a, op_b, out_ready,
        input  in_ready, out_valid, product
    );

    // Multiplier side.
    modport slave (
        input  in_valid, sign_a, sign_b, op_a, op_b, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/mul_addshift_radix.sv
// Iterative add-shift multiplier, RADIX_LOG2 multiplier bits per cycle, signed/unsigned per operand.
// Latency: DATA_W/RADIX_LOG2 cycles from accept to out_valid (shorter with MUL_ADDSHIFT_EARLY_TERM_EN).
// Backpressure: one op in flight; in_ready only in IDLE, product held with out_valid until out_ready.
// Optional feature macro: MUL_ADDSHIFT_EARLY_TERM_EN (exit as soon as the remaining multiplier digits are zero).
module mul_addshift_radix #(
    parameter int DATA_W     = 32,
    parameter int RADIX_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    mul_addshift_radix_if.slave      bus
);
    localparam int K     = RADIX_LOG2;
    localparam int N     = DATA_W / RADIX_LOG2;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if ((RADIX_LOG2 < 1) || (DATA_W % RADIX_LOG2 != 0)) begin : g_bad_radix
            $error("mul_addshift_radix: DATA_W must be a multiple of RADIX_LOG2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [2*DATA_W-1:0]    r_acc;
    logic [2*DATA_W-1:0]    r_product;
    logic [DATA_W-1:0]      r_mag_a;
    logic                   r_neg;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_accept;
    logic                   w_done;
    logic [DATA_W-1:0]      w_mag_a;
    logic [DATA_W-1:0]      w_mag_b;
    logic                   w_neg;
    logic [DATA_W+K-1:0]    w_pp;
    logic [DATA_W+K-1:0]    w_hi;
    logic [2*DATA_W+K-1:0]  w_cat;
    logic [2*DATA_W-1:0]    w_acc_step;
    logic [2*DATA_W-1:0]    w_acc_fin;
    logic [2*DATA_W-1:0]    w_res_fixed;

    assign bus.in_ready  = (r_state == S_IDLE) && !rst;
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.product   = r_product;
    assign w_accept      = bus.in_valid && bus.in_ready;

    // Magnitudes: negating the most negative value wraps to 2^(DATA_W-1), which is exact unsigned.
    assign w_mag_a = (bus.sign_a && bus.op_a[DATA_W-1]) ? -bus.op_a : bus.op_a;
    assign w_mag_b = (bus.sign_b && bus.op_b[DATA_W-1]) ? -bus.op_b : bus.op_b;
    assign w_neg   = (bus.sign_a & bus.op_a[DATA_W-1]) ^ (bus.sign_b & bus.op_b[DATA_W-1]);

    // One radix step: add |a| times the low multiplier digit into the high half, then shift by K.
    // The widened high half cannot overflow: hi < 2^W and |a|*digit <= (2^W-1)(2^K-1).
    assign w_pp       = {{K{1'b0}}, r_mag_a} * {{DATA_W{1'b0}}, r_acc[K-1:0]};
    assign w_hi       = {{K{1'b0}}, r_acc[2*DATA_W-1:DATA_W]} + w_pp;
    assign w_cat      = {w_hi, r_acc[DATA_W-1:0]};
    assign w_acc_step = (2*DATA_W)'(w_cat >> K);

`ifdef MUL_ADDSHIFT_EARLY_TERM_EN
    logic [31:0]        w_used_bits;
    logic [DATA_W-1:0]  w_rem_mask;
    // After this step the unconsumed multiplier bits sit in the low (DATA_W - used) bits of acc;
    // if they are all zero the remaining steps would only shift, so shift them all at once.
    assign w_used_bits = 32'(K) * (32'(r_cnt) + 32'd1);
    assign w_rem_mask  = {DATA_W{1'b1}} >> w_used_bits;
    assign w_done      = (r_cnt == LAST) || ((w_acc_step[DATA_W-1:0] & w_rem_mask) == '0);
    assign w_acc_fin   = w_acc_step >> (32'(DATA_W) - w_used_bits);
`else
    assign w_done      = (r_cnt == LAST);
    assign w_acc_fin   = w_acc_step;
`endif

    // Sign fix folded into the final step; -0 is 0 so a zero product stays zero.
    assign w_res_fixed = r_neg ? -w_acc_fin : w_acc_fin;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: accept in IDLE, iterate in CALC, hold in OUT until consumed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)      w_state_nxt = S_CALC;
            S_CALC:  if (w_done)        w_state_nxt = S_OUT;
            S_OUT:   if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, step the accumulator, capture the signed product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_product <= '0;
            r_mag_a   <= '0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mag_a <= w_mag_a;
                        r_neg   <= w_neg;
                        r_acc   <= {{DATA_W{1'b0}}, w_mag_b};
                        r_cnt   <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_done) r_product <= w_res_fixed;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_addshift_radix.sv
// Scoreboarded bench for mul_addshift_radix: K=2 main instance plus K=1 and K=4 latency instances.
// Latency: expected latency derived from the operand and build option.
// Backpressure: exercises out_ready low with in_valid asserted during OUT.
module tb_mul_addshift_radix;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_addshift_radix_if #(.DATA_W(32)) bus    ();
    mul_addshift_radix_if #(.DATA_W(32)) bus_k1 ();
    mul_addshift_radix_if #(.DATA_W(32)) bus_k4 ();

    // The K=1 and K=4 instances see the same stimulus as the main one.
    assign bus_k1.in_valid  = bus.in_valid;
    assign bus_k1.sign_a    = bus.sign_a;
    assign bus_k1.sign_b    = bus.sign_b;
    assign bus_k1.op_a      = bus.op_a;
    assign bus_k1.op_b      = bus.op_b;
    assign bus_k1.out_ready = bus.out_ready;
    assign bus_k4.in_valid  = bus.in_valid;
    assign bus_k4.sign_a    = bus.sign_a;
    assign bus_k4.sign_b    = bus.sign_b;
    assign bus_k4.op_a      = bus.op_a;
    assign bus_k4.op_b      = bus.op_b;
    assign bus_k4.out_ready = bus.out_ready;

    mul_addshift_radix #(.DATA_W(32), .RADIX_LOG2(2)) u_dut    (.clk(clk), .rst(rst), .bus(bus.slave));
    mul_addshift_radix #(.DATA_W(32), .RADIX_LOG2(1)) u_dut_k1 (.clk(clk), .rst(rst), .bus(bus_k1.slave));
    mul_addshift_radix #(.DATA_W(32), .RADIX_LOG2(4)) u_dut_k4 (.clk(clk), .rst(rst), .bus(bus_k4.slave));

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sa, input logic sb, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    function automatic int exp_lat(input int k, input logic sb, input logic [31:0] b);
        int lat;
        lat = 32 / k;
`ifdef MUL_ADDSHIFT_EARLY_TERM_EN
        begin
            logic [31:0] m;
            int          hi;
            m  = (sb && b[31]) ? -b : b;
            hi = 0;
            for (int i = 0; i < 32 / k; i++)
                if (((m >> (i * k)) & ((32'd1 << k) - 32'd1)) != 32'd0) hi = i;
            lat = hi + 1;
        end
`endif
        return lat;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every product handed off by the main instance must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) check("sb_product", bus.product, sb_q.pop_front());
            end
        end
    end

    task automatic start_op(input logic sa, input logic sb, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready && bus_k1.in_ready && bus_k4.in_ready) break;
            tick();
        end
        check("all_ready", 64'(bus.in_ready && bus_k1.in_ready && bus_k4.in_ready), 64'd1);
        bus.sign_a   = sa;
        bus.sign_b   = sb;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        sb_q.push_back(model(sa, sb, a, b));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic sa, input logic sb, input logic [31:0] a, input logic [31:0] b);
        int          l1, l2, l4;
        logic [63:0] p1, p2, p4, exp;
        l1 = 0; l2 = 0; l4 = 0;
        p1 = '0; p2 = '0; p4 = '0;
        exp = model(sa, sb, a, b);
        start_op(sa, sb, a, b);
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.out_valid    && l2 == 0) begin l2 = c; p2 = bus.product;    end
            if (bus_k1.out_valid && l1 == 0) begin l1 = c; p1 = bus_k1.product; end
            if (bus_k4.out_valid && l4 == 0) begin l4 = c; p4 = bus_k4.product; end
        end
        check({tag, "_lat_k2"},  64'(l2), 64'(exp_lat(2, sb, b)));
        check({tag, "_lat_k1"},  64'(l1), 64'(exp_lat(1, sb, b)));
        check({tag, "_lat_k4"},  64'(l4), 64'(exp_lat(4, sb, b)));
        check({tag, "_prod_k2"}, p2, exp);
        check({tag, "_prod_k1"}, p1, exp);
        check({tag, "_prod_k4"}, p4, exp);
    endtask

    initial begin
        logic [63:0] bp_exp;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.sign_a    = 1'b0;
        bus.sign_b    = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        tick();
        tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_product",   bus.product,        64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready",  64'(bus.in_ready),  64'd1);

        run_op("u_ffxff",   1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("s_m1x5",    1'b1, 1'b1, 32'hFFFF_FFFF, 32'd5);
        run_op("su_m1x2",   1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2);
        run_op("s_minxmin", 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000);
        run_op("s_minx1",   1'b1, 1'b1, 32'h8000_0000, 32'd1);
        run_op("u_123x3",   1'b0, 1'b0, 32'd123,       32'd3);
        run_op("u_bzero",   1'b0, 1'b0, 32'd5,         32'd0);
        run_op("s_neg0",    1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0);
        for (int i = 0; i < 4; i++)
            run_op("rnd", 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, $urandom);

        // Backpressure: product and out_valid hold, new requests are ignored.
        bus.out_ready = 1'b0;
        bp_exp = model(1'b0, 1'b0, 32'd12345, 32'd678);
        start_op(1'b0, 1'b0, 32'd12345, 32'd678);
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) break;
            tick();
        end
        check("bp_reached_out", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.op_a     = $urandom;
            bus.op_b     = $urandom;
            tick();
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_product",   bus.product,        bp_exp);
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_idle_in_ready",  64'(bus.in_ready),  64'd1);
        check("bp_idle_out_valid", 64'(bus.out_valid), 64'd0);

        // Reset after five iterations discards the operation.
        start_op(1'b0, 1'b0, 32'd1000, 32'd1000);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_product",   bus.product,        64'd0);
        sb_q.delete();
        rst = 1'b0;
        #1;
        check("mid_rst_rel_ready", 64'(bus.in_ready), 64'd1);
        run_op("post_rst_7x6", 1'b0, 1'b0, 32'd7, 32'd6);

        for (int i = 0; i < 5; i++) tick();
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
